// File: rtl/glyph_pkg.sv
// Shared types and constants for the glyph ROM reader and its ROM mux.
package glyph_pkg;

  localparam int unsigned GLYPH_W      = 8;
  localparam int unsigned GLYPH_H      = 16;
  localparam int unsigned GLYPH_ADDR_W = 7;
  localparam int unsigned NUM_GLYPHS   = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAST,
    PRESENT,
    DONE
  } glyph_state_t;

endpackage

// File: rtl/glyph_row_packer.sv
// Walks one glyph in a 1-bit registered ROM and hands out its rows as bytes
// over a valid/ready handshake, one row fetched at a time.
module glyph_row_packer #(
  parameter int unsigned GLYPH_W = 8,
  parameter int unsigned GLYPH_H = 16,
  parameter int unsigned ADDR_W  = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         glyph_id,
  output logic [3:0]         rom_sel,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic               rom_q,
  output logic [GLYPH_W-1:0] row_data,
  output logic [3:0]         row_index,
  output logic               row_valid,
  input  logic               row_ready,
  output logic               busy,
  output logic               done
);
  import glyph_pkg::*;

  localparam int unsigned ColW = $clog2(GLYPH_W);
  localparam int unsigned RowW = $clog2(GLYPH_H);

  glyph_state_t       state_q, state_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [GLYPH_W-1:0] shift_q, shift_d;
  logic [GLYPH_W-1:0] row_data_q, row_data_d;
  logic [3:0]         sel_q, sel_d;
  logic               capture_q;
  logic               handshake;

  assign handshake = row_valid & row_ready;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    sel_d      = sel_q;
    row_data_d = row_data_q;
    // ROM data trails its address by one cycle, so capture lags FETCH by one.
    shift_d    = capture_q ? {shift_q[GLYPH_W-2:0], rom_q} : shift_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = glyph_id;
          row_d   = '0;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        col_d = col_q + 1'b1;
        if (col_q == ColW'(GLYPH_W - 1)) begin
          state_d = LAST;
        end
      end
      LAST: begin
        row_data_d = shift_d;
        state_d    = PRESENT;
      end
      PRESENT: begin
        if (handshake) begin
          if (row_q == RowW'(GLYPH_H - 1)) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + 1'b1;
            col_d   = '0;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        row_d   = '0;
        col_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      sel_q      <= '0;
      shift_q    <= '0;
      row_data_q <= '0;
      capture_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      sel_q      <= sel_d;
      shift_q    <= shift_d;
      row_data_q <= row_data_d;
      capture_q  <= (state_q == FETCH);
    end
  end

  assign rom_sel     = sel_q;
  assign rom_address = ADDR_W'({row_q, col_q});
  assign row_data    = row_data_q;
  assign row_index   = row_q;
  assign row_valid   = (state_q == PRESENT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_glyph_row_packer.sv
// Bench for glyph_row_packer: registered ROM model plus a protocol-level
// model predicting row contents and handshake/done timing from the ready drive.
module tb_glyph_row_packer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] glyph_id;
  logic [3:0] rom_sel;
  logic [6:0] rom_address;
  logic       rom_q;
  logic [7:0] row_data;
  logic [3:0] row_index;
  logic       row_valid;
  logic       row_ready;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  logic [7:0] tbl [10][16];

  glyph_row_packer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .glyph_id    (glyph_id),
    .rom_sel     (rom_sel),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .row_data    (row_data),
    .row_index   (row_index),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Registered 1-bit ROM: address {row, col}, col 0 is the row's MSB.
  always @(posedge clock) begin
    if (rom_sel < 4'd10)
      rom_q <= tbl[int'(rom_sel)][int'(rom_address[6:3])][3'd7 - rom_address[2:0]];
    else
      rom_q <= 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rom_sel"}, rom_sel, 0);
    check({tag, ".rom_address"}, rom_address, 0);
    check({tag, ".row_data"}, row_data, 0);
    check({tag, ".row_index"}, row_index, 0);
    check({tag, ".row_valid"}, row_valid, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
  endtask

  // mode: 0 ready high, 1 fixed stall on one row, 2 random ready, 3 early ready
  task automatic do_read(input int gid, input int mode, input int stall_row,
                         input int stall_len, input bit intrude);
    int n, cur_row, valid_edge, done_edge, stalls, stall_cnt;
    int hs_seen, first_valid, dut_done_edge, done_pulses;
    bit exp_valid, exp_busy, exp_done, rdy;
    row_ready = (mode != 2);
    start     = 1'b1;
    glyph_id  = gid[3:0];
    @(posedge clock);
    @(negedge clock);
    start         = 1'b0;
    glyph_id      = 4'($urandom_range(0, 9));
    n             = 0;
    cur_row       = 0;
    valid_edge    = 9;
    done_edge     = -1;
    stalls        = 0;
    stall_cnt     = 0;
    hs_seen       = 0;
    first_valid   = -1;
    dut_done_edge = -1;
    done_pulses   = 0;
    while (1) begin
      exp_valid = (cur_row < 16) && (n >= valid_edge);
      exp_done  = (done_edge >= 0) && (n == done_edge);
      exp_busy  = (done_edge < 0) || (n <= done_edge);
      check($sformatf("g%0d.n%0d.row_valid", gid, n), row_valid, exp_valid);
      check($sformatf("g%0d.n%0d.done", gid, n), done, exp_done);
      check($sformatf("g%0d.n%0d.busy", gid, n), busy, exp_busy);
      if (exp_busy) check($sformatf("g%0d.n%0d.rom_sel", gid, n), rom_sel, gid);
      if (exp_valid) begin
        check($sformatf("g%0d.n%0d.row_index", gid, n), row_index, cur_row);
        check($sformatf("g%0d.n%0d.row_data", gid, n), row_data, tbl[gid][cur_row]);
      end
      if (cur_row < 16 && n >= valid_edge - 9 && n <= valid_edge - 2)
        check($sformatf("g%0d.n%0d.rom_address", gid, n), rom_address,
              {cur_row[3:0], 3'(n - (valid_edge - 9))});
      if (row_valid === 1'b1 && first_valid < 0) first_valid = n;
      if (done === 1'b1) begin
        done_pulses++;
        dut_done_edge = n;
      end
      // Decide ready for the next edge.
      if (exp_valid) begin
        rdy = 1'b1;
        if (mode == 1 && cur_row == stall_row && stall_cnt < stall_len) begin
          rdy = 1'b0;
          stall_cnt++;
        end else if (mode == 2) begin
          rdy = ($urandom_range(0, 3) != 0);
        end
        if (!rdy) stalls++;
      end else begin
        rdy = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      row_ready = rdy;
      if (intrude && cur_row == 4 && n == valid_edge - 5) begin
        start    = 1'b1;
        glyph_id = 4'd2;
      end else begin
        start = 1'b0;
      end
      if (row_valid === 1'b1 && rdy) hs_seen++;
      if (exp_valid && rdy) begin
        if (cur_row == 15) done_edge = n + 1;
        valid_edge = n + 1 + 9;
        cur_row++;
      end
      if (done_edge >= 0 && n == done_edge + 1) break;
      if (n >= 3000) begin
        fails++;
        $error("FAIL g%0d.timeout observed=n%0d expected=done", gid, n);
        break;
      end
      n++;
      @(posedge clock);
      @(negedge clock);
    end
    start = 1'b0;
    check($sformatf("g%0d.handshakes", gid), hs_seen, 16);
    check($sformatf("g%0d.first_valid_edge", gid), first_valid, 9);
    check($sformatf("g%0d.done_pulses", gid), done_pulses, 1);
    check($sformatf("g%0d.done_edge", gid), dut_done_edge, 160 + stalls);
  endtask

  initial begin
    logic [7:0] g5 [16];
    g5 = '{8'h00, 8'h00, 8'h00, 8'h3E, 8'h7C, 8'h40, 8'h6C, 8'h4E,
           8'h0E, 8'hEE, 8'hEE, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int g = 0; g < 10; g++)
      for (int r = 0; r < 16; r++) tbl[g][r] = 8'h00;
    for (int r = 0; r < 16; r++) tbl[5][r] = g5[r];

    reset     = 1'b1;
    start     = 1'b0;
    glyph_id  = 4'd0;
    row_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Idle with start low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check($sformatf("idle%0d.busy", i), busy, 0);
      check($sformatf("idle%0d.row_valid", i), row_valid, 0);
      check($sformatf("idle%0d.rom_address", i), rom_address, 0);
      check($sformatf("idle%0d.done", i), done, 0);
    end

    do_read(5, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clock);
    do_read(5, 1, 6, 7, 1'b0);
    repeat (2) @(negedge clock);
    do_read(5, 0, 0, 0, 1'b1);
    repeat (2) @(negedge clock);

    // Reset in the middle of row 9's fetch.
    row_ready = 1'b1;
    start     = 1'b1;
    glyph_id  = 4'd5;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (93) @(negedge clock);
    check("midreset.rom_address", rom_address, {4'd9, 3'd3});
    check("midreset.busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midreset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check($sformatf("postreset%0d.done", i), done, 0);
      check($sformatf("postreset%0d.busy", i), busy, 0);
    end
    do_read(5, 0, 0, 0, 1'b0);

    // Ready held high well before start.
    row_ready = 1'b1;
    repeat (5) @(negedge clock);
    do_read(5, 3, 0, 0, 1'b0);
    repeat (2) @(negedge clock);

    // Random glyph contents with random backpressure.
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) tbl[7 - k][r] = 8'($urandom);
      do_read(7 - k, 2, 0, 0, 1'b0);
      repeat (2) @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/glyph_row_packer.md
# glyph_row_packer

- Reads one 8x16 glyph from the 1-bit registered character ROMs (ROM_0..ROM_9, 7-bit address, one-cycle read latency).
- Issues the ROM addresses itself, and deserializes the returned bit stream into 16 row bytes.
- Delivers each row over a valid/ready handshake to the display-side pixel writer.
- Sits directly between the glyph ROM mux and the display driver.

## Interface
Parameters:
- GLYPH_W, 8, pixels per row (bits per output byte)
- GLYPH_H, 16, rows per glyph
- ADDR_W, 7, ROM address width (log2(GLYPH_W*GLYPH_H))

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request to read one glyph; sampled only in IDLE
- glyph_id  in  4  glyph code (0..9), latched on accepted start
- rom_sel  out  4  latched glyph_id; drives the ROM output mux
- rom_address  out  ADDR_W  ROM read address = {row, col}
- rom_q  in  1  ROM data; valid the cycle after its address was presented
- row_data  out  GLYPH_W  packed row; col 0 (leftmost pixel) in MSB
- row_index  out  4  row number of row_data
- row_valid  out  1  row_data/row_index valid
- row_ready  in  1  consumer accepts the row when row_valid & row_ready at a clock edge
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last row is accepted

## Operation
- FSM states: IDLE, FETCH, LAST, PRESENT, DONE.
- IDLE:
  - start=1 → latch glyph_id into rom_sel, row=0, col=0, go to FETCH.
  - start=0 → stay.
- FETCH:
  - rom_address = row*8+col; col increments each cycle, 0..7.
  - After col=7 is issued, go to LAST.
- Capture:
  - Capture is the FETCH state delayed one cycle.
  - When enabled, shift register <= {shift[6:0], rom_q}.
  - LAST is the capture of col 7.
- LAST → PRESENT:
  - row_data is loaded from the completed shift register.
  - row_index = row, row_valid = 1.
- PRESENT, on handshake:
  - row < 15 → row+1, col=0, FETCH.
  - row = 15 → DONE.
  - Without a handshake, all outputs hold stable.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy is ignored; glyph_id changes after acceptance have no effect.
- row_ready may be high before row_valid; only the coincident edge counts.
- rom_address = {row, col}; it reads 0 in IDLE and after reset.
- Reset at any point:
  - state IDLE, row/col/shift cleared.
  - Outputs return to their reset values; no done pulse for the aborted glyph.

## Timing
- Reset values:
  - rom_sel=0, rom_address=0, row_data=0, row_index=0.
  - row_valid=0, busy=0, done=0.
- Edge E0 samples start; busy high after E0.
- Address for col k is presented after edge E(k); rom_q for it is valid after E(k+1) and sampled at E(k+2).
- row_valid rises after E9, i.e. 9 edges after start.
- With row_ready held high:
  - Each row costs 10 edges (9 fetch/pack + 1 handshake).
  - The row-15 handshake is at E160; done is high during the cycle after E160; IDLE after E161.
- Consumer stall of N cycles on any row delays all later events by N.
- Throughput: no fetch overlap with PRESENT (ROM is cheap; simplicity preferred).

## Structure
- Shared package glyph_pkg holds:
  - State enum glyph_state_t {IDLE, FETCH, LAST, PRESENT, DONE}.
  - Constants GLYPH_W=8, GLYPH_H=16, GLYPH_ADDR_W=7.
  - Glyph-code constant NUM_GLYPHS=10, shared with the ROM mux.
- No sub-module: FSM, row/col counters and shift register stay inline.
- ROM mux lives outside this block, driven by rom_sel.

## Test plan
- Bench uses a registered 1-bit ROM model loaded with glyph 5: rows 3..11 = 3E 7C 40 6C 4E 0E EE EE 7C, all other rows 00.
- Reset, idle: start=0 for 20 cycles → busy=0, row_valid=0, rom_address=0, done never pulses.
- Full read, ready always high, glyph_id=5:
  - 16 rows with row_index 0..15 and data exactly as the loaded table.
  - First row_valid 9 edges after start; done single pulse after E160; rom_sel=5 throughout.
- Backpressure:
  - row_ready low for 7 cycles on row 6 → row_data=6C and row_index=6 stable throughout.
  - Accepted exactly once; done delayed by 7 cycles.
- Start while busy:
  - Second start with glyph_id=2 at row 4 → ignored.
  - rom_sel stays 5; exactly 16 rows and one done.
- Reset mid-operation:
  - reset during FETCH of row 9 → next cycle all outputs at reset values, no done.
  - A new start reads row 0 = 00 with normal 9-edge latency.
- Early ready:
  - row_ready high before start and kept high → no row accepted before row_valid.
  - Handshake count = 16.
